// File: rtl/col_block_result_packer.sv
// Column-block result packer: gathers PACK_NUM scalar FP sums into one wide
// word, tags the word that holds the last result of a tile, and queues the
// words in a small FIFO for the write-back path.
// Optional build macro PACKER_FLUSH_EN adds a flush input that closes a
// partial word early (zero padded, tagged last).
module col_block_result_packer #(
   parameter int FP_WIDTH   = 16,
   parameter int PACK_NUM   = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int MACRO_ROW  = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [FP_WIDTH-1:0]          fp_col_block_result,
   input  logic                         fp_col_block_result_vld,
   output logic                         fp_col_block_result_rdy,
   output logic [PACK_NUM*FP_WIDTH-1:0] pack_data,
   output logic                         pack_vld,
   input  logic                         pack_rdy,
   output logic                         pack_last,
   output logic                         tile_done
`ifdef PACKER_FLUSH_EN
   ,
   input  logic                         flush
`endif
);

   localparam int WW = PACK_NUM * FP_WIDTH;
   localparam int LW = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
   localparam int RW = (MACRO_ROW > 1) ? $clog2(MACRO_ROW) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [LW-1:0] lane_cnt_q, lane_cnt_d;
   logic [RW-1:0] res_cnt_q, res_cnt_d;
   logic [WW-1:0] asm_q, asm_d;
   logic [WW-1:0] asmWithLane;

   logic [WW:0]   fifo_mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          tile_done_q;

   logic          fifoFull, fifoEmpty;
   logic          laneEnd, tileEnd, closeCond;
   logic          accept, pushReq, push, pop;
   logic [WW:0]   pushWord;
   logic [WW:0]   headEntry;

`ifdef PACKER_FLUSH_EN
   logic          flush_pend_q, flush_pend_d;
`endif

   assign fifoFull  = (count_q == (AW+1)'(FIFO_DEPTH));
   assign fifoEmpty = (count_q == '0);
   assign laneEnd   = (lane_cnt_q == LW'(PACK_NUM-1));
   assign tileEnd   = (res_cnt_q == RW'(MACRO_ROW-1));
   assign closeCond = laneEnd | tileEnd;

   // Ready comes only from registered state so it never combinationally depends on vld or pack_rdy.
`ifdef PACKER_FLUSH_EN
   assign fp_col_block_result_rdy = ~(closeCond & fifoFull) & ~flush_pend_q;
`else
   assign fp_col_block_result_rdy = ~(closeCond & fifoFull);
`endif

   assign accept = fp_col_block_result_vld & fp_col_block_result_rdy;
   assign push   = pushReq & ~fifoFull;
   assign pop    = ~fifoEmpty & pack_rdy;

   // Assembly word as it looks once the incoming result is dropped into its lane.
   always_comb begin
      asmWithLane = asm_q;
      for (int i = 0; i < PACK_NUM; i++) begin
         if (accept && (lane_cnt_q == LW'(i))) begin
            asmWithLane[i*FP_WIDTH +: FP_WIDTH] = fp_col_block_result;
         end
      end
   end

   // Lane/tile counting and word-close decisions, producing the FIFO push request.
   always_comb begin
      lane_cnt_d = lane_cnt_q;
      res_cnt_d  = res_cnt_q;
      asm_d      = asm_q;
      pushReq    = 1'b0;
      pushWord   = '0;
`ifdef PACKER_FLUSH_EN
      flush_pend_d = flush_pend_q;
`endif
      if (accept) begin
         if (closeCond) begin
            pushReq    = 1'b1;
            pushWord   = {tileEnd, asmWithLane};
            lane_cnt_d = '0;
            asm_d      = '0;
            res_cnt_d  = tileEnd ? '0 : res_cnt_q + 1'b1;
         end else begin
            lane_cnt_d = lane_cnt_q + 1'b1;
            res_cnt_d  = res_cnt_q + 1'b1;
            asm_d      = asmWithLane;
         end
      end
`ifdef PACKER_FLUSH_EN
      if (flush_pend_q) begin
         if (!fifoFull) begin
            pushReq      = 1'b1;
            pushWord     = {1'b1, asm_q};
            lane_cnt_d   = '0;
            res_cnt_d    = '0;
            asm_d        = '0;
            flush_pend_d = 1'b0;
         end
      end else if (flush && ((accept && !closeCond) || (!accept && (lane_cnt_q != '0)))) begin
         if (!fifoFull) begin
            pushReq    = 1'b1;
            pushWord   = {1'b1, asmWithLane};
            lane_cnt_d = '0;
            res_cnt_d  = '0;
            asm_d      = '0;
         end else begin
            flush_pend_d = 1'b1;
         end
      end
`endif
   end

   // FIFO pointer and occupancy next-state; a simultaneous push and pop leaves occupancy unchanged.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
   end

   // Packing state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_cnt_q <= '0;
         res_cnt_q  <= '0;
         asm_q      <= '0;
      end else begin
         lane_cnt_q <= lane_cnt_d;
         res_cnt_q  <= res_cnt_d;
         asm_q      <= asm_d;
      end
   end

`ifdef PACKER_FLUSH_EN
   // Remembers a flush that arrived while the FIFO had no room.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_pend_q <= 1'b0;
      end else begin
         flush_pend_q <= flush_pend_d;
      end
   end
`endif

   // FIFO storage of {last, data}, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            fifo_mem_q[wr_ptr_q] <= pushWord;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // One-cycle tile_done pulse after the last word of a tile leaves the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tile_done_q <= 1'b0;
      end else begin
         tile_done_q <= pop & headEntry[WW];
      end
   end

   assign headEntry = fifo_mem_q[rd_ptr_q];
   assign pack_vld  = ~fifoEmpty;
   assign pack_data = fifoEmpty ? '0 : headEntry[WW-1:0];
   assign pack_last = ~fifoEmpty & headEntry[WW];
   assign tile_done = tile_done_q;

endmodule
